// File: rtl/core_mc_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer; owns the PC and a single commit point. Optional CORE_MC_PERF_CNT_EN adds perf counters.
// Latency: 3 cycles per ALU instruction with zero-wait memories, plus one cycle per memory wait cycle.
// Backpressure: req is held until ack; a missing ack halts with an error after TIMEOUT_CYCLES wait cycles.
module core_mc_sequencer #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  exu_mem_op,
    input  logic                  exu_gpr_wen,
    input  logic                  exu_mem_wen,
    input  logic                  exu_jump_en,
    input  logic [ADDR_WIDTH-1:0] exu_dnpc,
    input  logic                  exu_halt,
    output logic                  dmem_req,
    input  logic                  dmem_ack,
    output logic                  gpr_wen,
    output logic                  mem_wen,
    output logic                  commit,
    output logic                  halted,
    output logic [1:0]            err_code
`ifdef CORE_MC_PERF_CNT_EN
    ,
    output logic [63:0]           perf_cycles,
    output logic [63:0]           perf_instret
`endif
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [15:0]             wait_cnt;
    logic                    gpr_wen_r, mem_wen_r, jump_r, halt_r;
    logic [ADDR_WIDTH-1:0]   dnpc_r;
    logic [ADDR_WIDTH-1:0]   pc_nxt;
    logic                    misaligned;
    logic                    wait_expired;

    assign pc_nxt       = jump_r ? dnpc_r : pc + ADDR_WIDTH'(4);
    assign misaligned   = |pc_nxt[1:0];
    // Expiry only matters when no ack arrived this cycle; an ack on the last cycle wins.
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign imem_addr    = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:   state_nxt = S_FETCH;
            S_FETCH: if (imem_ack)          state_nxt = S_EXEC;
                     else if (wait_expired) state_nxt = S_HALT;
            S_EXEC:  state_nxt = exu_mem_op ? S_MEM : S_WB;
            S_MEM:   if (dmem_ack)          state_nxt = S_WB;
                     else if (wait_expired) state_nxt = S_HALT;
            S_WB:    state_nxt = (misaligned || halt_r) ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        gpr_wen  = 1'b0;
        mem_wen  = 1'b0;
        commit   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                mem_wen  = mem_wen_r && dmem_ack;
            end
            S_WB: begin
                commit  = 1'b1;
                gpr_wen = gpr_wen_r;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            inst      <= 32'h0000_0013;
            err_code  <= 2'd0;
            wait_cnt  <= 16'd0;
            gpr_wen_r <= 1'b0;
            mem_wen_r <= 1'b0;
            jump_r    <= 1'b0;
            halt_r    <= 1'b0;
            dnpc_r    <= '0;
        end else begin
            case (state)
                S_RST: wait_cnt <= 16'd0;
                S_FETCH: begin
                    if (imem_ack)          inst     <= imem_rdata;
                    else if (wait_expired) err_code <= 2'd1;
                    else                   wait_cnt <= wait_cnt + 16'd1;
                end
                S_EXEC: begin
                    gpr_wen_r <= exu_gpr_wen;
                    mem_wen_r <= exu_mem_wen;
                    jump_r    <= exu_jump_en;
                    dnpc_r    <= exu_dnpc;
                    halt_r    <= exu_halt;
                    wait_cnt  <= 16'd0;
                end
                S_MEM: begin
                    if (!dmem_ack) begin
                        if (wait_expired) err_code <= 2'd2;
                        else              wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_WB: begin
                    // A misaligned target still retires the instruction but leaves pc at it.
                    if (misaligned) err_code <= 2'd3;
                    else            pc       <= pc_nxt;
                    wait_cnt <= 16'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef CORE_MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles  <= 64'd0;
            perf_instret <= 64'd0;
        end else begin
            if (state != S_RST && state != S_HALT) perf_cycles <= perf_cycles + 64'd1;
            if (commit)                            perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule
